// File: rtl/prio_min_select_if.sv
// Handshake bundle between the subtract stage, the min-select block and its consumer.
// The block is the slave: it takes differences in and hands frame results out.
interface prio_min_select_if #(
   parameter int WIDTH = 64,
   parameter int N     = 8
);
   localparam int IDXW = $clog2(N);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_min;
   logic [IDXW-1:0]  out_idx;
   logic [IDXW:0]    out_neg_cnt;

   modport master (
      output in_valid,
      input  in_ready,
      output in_data,
      input  out_valid,
      output out_ready,
      input  out_min,
      input  out_idx,
      input  out_neg_cnt
   );

   modport slave (
      input  in_valid,
      output in_ready,
      input  in_data,
      output out_valid,
      input  out_ready,
      output out_min,
      output out_idx,
      output out_neg_cnt
   );
endinterface

// File: rtl/prio_min_select.sv
// Frame-wise signed minimum finder: over N accepted differences it tracks the smallest
// value, its arrival position and the count of negative entries, then holds the result.
module prio_min_select #(
   parameter int WIDTH = 64,
   parameter int N     = 8
) (
   input logic            clk,
   input logic            rst_n,
   prio_min_select_if.slave bus
);
   localparam int IDXW = $clog2(N);
   localparam int NEGW = IDXW + 1;
   localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

   typedef enum logic {
      ACCUM,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [IDXW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] min_q, min_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [NEGW-1:0]  neg_q, neg_d;
   logic             in_ready_c;
   logic             out_valid_c;
   logic             is_neg;
   logic             is_smaller;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         cnt_q   <= '0;
         min_q   <= '0;
         idx_q   <= '0;
         neg_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         min_q   <= min_d;
         idx_q   <= idx_d;
         neg_q   <= neg_d;
      end
   end

   // Strict less-than keeps the earliest index on ties; the sign bit alone marks a negative.
   assign is_neg     = bus.in_data[WIDTH-1];
   assign is_smaller = $signed(bus.in_data) < $signed(min_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      min_d       = min_q;
      idx_d       = idx_q;
      neg_d       = neg_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state_q)
         ACCUM: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               if (cnt_q == '0) begin
                  min_d = bus.in_data;
                  idx_d = '0;
                  neg_d = NEGW'(is_neg);
               end else begin
                  if (is_smaller) begin
                     min_d = bus.in_data;
                     idx_d = cnt_q;
                  end
                  neg_d = neg_q + NEGW'(is_neg);
               end
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) begin
               state_d = ACCUM;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.out_valid   = out_valid_c;
   assign bus.out_min     = min_q;
   assign bus.out_idx     = idx_q;
   assign bus.out_neg_cnt = neg_q;
endmodule

// File: tb/tb_prio_min_select.sv
// Directed bench for prio_min_select (N=4, WIDTH=8); expected frame results go into a
// scoreboard queue and a monitor compares them whenever a result is handed off.
module tb_prio_min_select;
   localparam int WIDTH = 8;
   localparam int N     = 4;

   typedef struct {
      int min_v;
      int idx_v;
      int neg_v;
   } exp_t;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   int   cyc;
   logic prev_ov;
   exp_t sb[$];
   int   rise_cyc[$];

   prio_min_select_if #(.WIDTH(WIDTH), .N(N)) bus ();

   prio_min_select #(.WIDTH(WIDTH), .N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one input beat at the falling edge and waits (bounded) for the block to take it.
   task automatic apply_stimulus(input logic valid, input int data);
      int wait_cnt;
      @(negedge clk);
      bus.in_valid = valid;
      bus.in_data  = WIDTH'(data);
      wait_cnt = 0;
      while (valid && !bus.in_ready && wait_cnt < 50) begin
         @(negedge clk);
         wait_cnt++;
      end
      if (valid && !bus.in_ready) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL in_ready_timeout: in_ready stayed 0, expected 1");
      end
   endtask

   task automatic go_idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic push_exp(input int m, input int i, input int n);
      exp_t e;
      e.min_v = m;
      e.idx_v = i;
      e.neg_v = n;
      sb.push_back(e);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && !prev_ov) rise_cyc.push_back(cyc);
      prev_ov <= rst_n && bus.out_valid;
   end

   // Monitor: a result counts as delivered when valid and ready meet before the next rising edge.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL unexpected_result: got min %0d with no frame pending",
                        int'($signed(bus.out_min)));
            end else begin
               exp_t e;
               e = sb.pop_front();
               check_output("sb_min", int'($signed(bus.out_min)), e.min_v);
               check_output("sb_idx", int'(bus.out_idx), e.idx_v);
               check_output("sb_neg", int'(bus.out_neg_cnt), e.neg_v);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vectors       = 0;
      miscompares   = 0;
      cyc           = 0;
      prev_ov       = 1'b0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      #1;
      check_output("rst_out_valid", int'(bus.out_valid), 0);
      check_output("rst_out_min", int'($signed(bus.out_min)), 0);
      check_output("rst_out_idx", int'(bus.out_idx), 0);
      check_output("rst_out_neg", int'(bus.out_neg_cnt), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_output("rst_in_ready", int'(bus.in_ready), 1);

      // Mixed-sign frame with a tie on -3: earlier index wins.
      $display("[TB] frame 5,-3,7,-3");
      bus.out_ready = 1'b1;
      push_exp(-3, 1, 2);
      apply_stimulus(1'b1, 5);
      apply_stimulus(1'b1, -3);
      apply_stimulus(1'b1, 7);
      apply_stimulus(1'b1, -3);
      go_idle();
      check_output("f1_out_valid", int'(bus.out_valid), 1);
      check_output("f1_in_ready", int'(bus.in_ready), 0);
      @(negedge clk);
      check_output("f1_after_valid", int'(bus.out_valid), 0);
      check_output("f1_after_ready", int'(bus.in_ready), 1);

      // Downstream stall: result must hold and input must stay blocked.
      $display("[TB] frame 10,20,30,40 with stall");
      bus.out_ready = 1'b0;
      push_exp(10, 0, 0);
      apply_stimulus(1'b1, 10);
      apply_stimulus(1'b1, 20);
      apply_stimulus(1'b1, 30);
      apply_stimulus(1'b1, 40);
      go_idle();
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         check_output("stall_valid", int'(bus.out_valid), 1);
         check_output("stall_in_ready", int'(bus.in_ready), 0);
         check_output("stall_min", int'($signed(bus.out_min)), 10);
         check_output("stall_idx", int'(bus.out_idx), 0);
         check_output("stall_neg", int'(bus.out_neg_cnt), 0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check_output("stall_release_valid", int'(bus.out_valid), 0);
      check_output("stall_release_ready", int'(bus.in_ready), 1);

      // Extreme values: most negative must win without overflow.
      $display("[TB] frame -128,127,0,-1");
      push_exp(-128, 0, 2);
      apply_stimulus(1'b1, -128);
      apply_stimulus(1'b1, 127);
      apply_stimulus(1'b1, 0);
      apply_stimulus(1'b1, -1);
      go_idle();
      check_output("ext_out_valid", int'(bus.out_valid), 1);

      // Upstream bubbles: invalid beats carry junk that must be ignored.
      $display("[TB] frame with in_valid gaps");
      push_exp(1, 3, 0);
      apply_stimulus(1'b1, 3);
      apply_stimulus(1'b0, -100);
      apply_stimulus(1'b0, -100);
      apply_stimulus(1'b1, 2);
      apply_stimulus(1'b1, 9);
      apply_stimulus(1'b0, -100);
      check_output("gap_no_early_valid", int'(bus.out_valid), 0);
      apply_stimulus(1'b1, 1);
      go_idle();
      check_output("gap_out_valid", int'(bus.out_valid), 1);

      // Reset in the middle of a frame discards the partial result.
      $display("[TB] reset mid-frame");
      apply_stimulus(1'b1, -5);
      apply_stimulus(1'b1, -6);
      go_idle();
      rst_n = 1'b0;
      #1;
      check_output("midrst_valid", int'(bus.out_valid), 0);
      check_output("midrst_neg", int'(bus.out_neg_cnt), 0);
      check_output("midrst_min", int'($signed(bus.out_min)), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_output("midrst_in_ready", int'(bus.in_ready), 1);
      push_exp(4, 0, 0);
      apply_stimulus(1'b1, 4);
      apply_stimulus(1'b1, 4);
      apply_stimulus(1'b1, 4);
      check_output("midrst_no_early_valid", int'(bus.out_valid), 0);
      apply_stimulus(1'b1, 4);
      check_output("midrst_still_invalid", int'(bus.out_valid), 0);
      go_idle();
      check_output("midrst_out_valid", int'(bus.out_valid), 1);
      @(negedge clk);

      // Two frames back to back; result spacing must be exactly N+1 cycles.
      $display("[TB] back-to-back frames");
      push_exp(7, 2, 0);
      push_exp(-2, 0, 2);
      apply_stimulus(1'b1, 9);
      apply_stimulus(1'b1, 8);
      apply_stimulus(1'b1, 7);
      apply_stimulus(1'b1, 100);
      apply_stimulus(1'b1, -2);
      apply_stimulus(1'b1, 50);
      apply_stimulus(1'b1, -2);
      apply_stimulus(1'b1, 3);
      go_idle();
      check_output("b2b_out_valid", int'(bus.out_valid), 1);
      repeat (3) @(negedge clk);
      if (rise_cyc.size() >= 2) begin
         check_output("b2b_period", rise_cyc[rise_cyc.size()-1] - rise_cyc[rise_cyc.size()-2], N + 1);
      end else begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL b2b_period: saw %0d result edges, expected at least 2", rise_cyc.size());
      end
      check_output("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
